// File: rtl/pixel_stream_loader_if.sv
// pixel_stream_loader_if: AXI4-Stream pixel channel between a video source and the loader
interface pixel_stream_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tuser;
  logic                    tlast;
  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/pixel_stream_loader.sv
// pixel_stream_loader: turns a row-major AXI4-Stream pixel raster into framebuffer writes
module pixel_stream_loader #(
  parameter int N_ROWS_MAX     = 64,
  parameter int N_COLS_MAX     = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int CTRL_REG_WIDTH = 32,
  parameter int ADDR_WIDTH     = $clog2(N_ROWS_MAX * N_COLS_MAX)
) (
  input  logic                      S_AXIS_ACLK,
  input  logic                      S_AXIS_ARESETN,
  pixel_stream_loader_if.slave      s_axis,
  input  logic                      ctrl_en,
  input  logic [CTRL_REG_WIDTH-1:0] ctrl_n_rows,
  input  logic [CTRL_REG_WIDTH-1:0] ctrl_n_cols,
  input  logic                      i_swap_ack,
  input  logic                      i_status_clr,
  output logic                      o_we,
  output logic [ADDR_WIDTH-1:0]     o_waddr,
  output logic [DATA_WIDTH-1:0]     o_wdata,
  output logic [DATA_WIDTH/8-1:0]   o_wstrb,
  output logic                      o_frame_done,
  output logic [3:0]                o_status
);
  localparam int CW = $clog2(N_COLS_MAX) + 1;
  localparam int RW = $clog2(N_ROWS_MAX) + 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, RESYNC, WAIT_SWAP} state_t;
  state_t                state, nxt;
  logic [CW-1:0]         col, n_cols, c, nc;
  logic [RW-1:0]         row, n_rows, r, nr;
  logic [ADDR_WIDTH-1:0] addr, a;
  logic acc, sof, bad, last_col, last_row, pix, short_err, long_err, ok, done, early;
  // A start-of-frame beat is evaluated as position (0,0) against the freshly presented
  // geometry, so restarts and single-column frames go through the same row checks.
  always_comb begin
    acc       = s_axis.tvalid & s_axis.tready;
    sof       = acc & ctrl_en & s_axis.tuser & (state != WAIT_SWAP);
    bad       = (ctrl_n_rows == '0) || (ctrl_n_cols == '0) ||
                (ctrl_n_rows > CTRL_REG_WIDTH'(N_ROWS_MAX)) ||
                (ctrl_n_cols > CTRL_REG_WIDTH'(N_COLS_MAX));
    c         = sof ? '0 : col;
    r         = sof ? '0 : row;
    a         = sof ? '0 : addr;
    nc        = sof ? CW'(ctrl_n_cols) : n_cols;
    nr        = sof ? RW'(ctrl_n_rows) : n_rows;
    last_col  = c == nc - CW'(1);
    last_row  = r == nr - RW'(1);
    pix       = acc & ctrl_en & (sof ? !bad : state == ACTIVE);
    short_err = pix & s_axis.tlast & !last_col;
    long_err  = pix & last_col & !s_axis.tlast;
    ok        = pix & !short_err & !long_err;
    done      = ok & last_col & last_row;
    early     = acc & ctrl_en & s_axis.tuser & (state == ACTIVE);
    nxt       = !ctrl_en               ? IDLE :
                (sof & bad)            ? IDLE :
                (short_err | long_err) ? RESYNC :
                done                   ? WAIT_SWAP :
                ok                     ? ACTIVE :
                (state == WAIT_SWAP && i_swap_ack) ? IDLE : state;
  end
  // State, counters, latched geometry, registered write port and sticky status.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state        <= IDLE;
      s_axis.tready <= 1'b0;
      col          <= '0;
      row          <= '0;
      addr         <= '0;
      n_cols       <= '0;
      n_rows       <= '0;
      o_we         <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_wstrb      <= '0;
      o_frame_done <= 1'b0;
      o_status     <= '0;
    end else begin
      state         <= nxt;
      s_axis.tready <= ctrl_en & (nxt != WAIT_SWAP);
      o_we          <= ok;
      o_frame_done  <= done;
      o_status      <= (o_status & ~{4{i_status_clr}}) | {sof & bad, early, long_err, short_err};
      if (sof && !bad) begin
        n_cols <= nc;
        n_rows <= nr;
      end
      if (ok) begin
        o_waddr <= a;
        o_wdata <= s_axis.tdata;
        o_wstrb <= s_axis.tkeep;
        col     <= last_col ? '0 : c + CW'(1);
        row     <= done ? '0 : last_col ? r + RW'(1) : r;
        addr    <= done ? '0 : a + ADDR_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_loader.sv
// tb_pixel_stream_loader: directed scenarios for the stream-to-framebuffer loader
module tb_pixel_stream_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl_en = 1'b1;
  logic [31:0] ctrl_n_rows = 32'd2;
  logic [31:0] ctrl_n_cols = 32'd4;
  logic        swap_ack = 1'b0;
  logic        status_clr = 1'b0;
  logic        o_we;
  logic [13:0] o_waddr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_frame_done;
  logic [3:0]  o_status;
  int          compared = 0;
  int          mismatched = 0;
  logic        acc;

  pixel_stream_loader_if #(.DATA_WIDTH(32)) s_axis ();

  pixel_stream_loader dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .s_axis        (s_axis),
    .ctrl_en       (ctrl_en),
    .ctrl_n_rows   (ctrl_n_rows),
    .ctrl_n_cols   (ctrl_n_cols),
    .i_swap_ack    (swap_ack),
    .i_status_clr  (status_clr),
    .o_we          (o_we),
    .o_waddr       (o_waddr),
    .o_wdata       (o_wdata),
    .o_wstrb       (o_wstrb),
    .o_frame_done  (o_frame_done),
    .o_status      (o_status)
  );

  always #5 clk = ~clk;

  // Presents one beat, waits (bounded) for TREADY, returns 1ns after the accepting edge.
  task automatic beat(input logic [31:0] d, input logic u, input logic l, output logic ok);
    int n;
    n = 0;
    @(negedge clk);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    s_axis.tkeep  = d[3:0];
    s_axis.tuser  = u;
    s_axis.tlast  = l;
    while (!s_axis.tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = s_axis.tready;
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic pulse_swap();
    @(negedge clk);
    swap_ack = 1'b1;
    @(negedge clk);
    swap_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if (s_axis.tready !== 1'b0 || o_we !== 1'b0 || o_status !== 4'h0 || o_frame_done !== 1'b0 || o_waddr !== '0) begin
      mismatched++;
      $display("FAIL reset: tready=%b we=%b status=%h done=%b addr=%0d, required all zero",
               s_axis.tready, o_we, o_status, o_frame_done, o_waddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (s_axis.tready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_tready: got %b required 1", s_axis.tready);
    end
  endtask

  task automatic test_frame();
    for (int i = 0; i < 8; i++) begin
      beat(32'h10 + i, i == 0, i == 3 || i == 7, acc);
      compared++;
      if (acc !== 1'b1 || o_we !== 1'b1 || o_waddr !== 14'(i) || o_wdata !== 32'h10 + i ||
          o_wstrb !== 4'(i) || o_frame_done !== (i == 7)) begin
        mismatched++;
        $display("FAIL frame_beat%0d: acc=%b we=%b addr=%0d data=%h strb=%h done=%b, required acc=1 we=1 addr=%0d data=%h strb=%h done=%b",
                 i, acc, o_we, o_waddr, o_wdata, o_wstrb, o_frame_done, i, 32'h10 + i, 4'(i), i == 7);
      end
    end
    compared++;
    if (s_axis.tready !== 1'b0) begin
      mismatched++;
      $display("FAIL wait_swap_tready: got %b required 0", s_axis.tready);
    end
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (s_axis.tready !== 1'b0 || o_we !== 1'b0 || o_frame_done !== 1'b0) begin
      mismatched++;
      $display("FAIL wait_swap_hold: tready=%b we=%b done=%b, required 0 0 0", s_axis.tready, o_we, o_frame_done);
    end
    pulse_swap();
    compared++;
    if (s_axis.tready !== 1'b1 || o_status !== 4'h0) begin
      mismatched++;
      $display("FAIL swap_ack: tready=%b status=%h, required tready=1 status=0", s_axis.tready, o_status);
    end
  endtask

  task automatic test_short_line();
    beat(32'h30, 1'b1, 1'b0, acc);
    beat(32'h31, 1'b0, 1'b0, acc);
    beat(32'h32, 1'b0, 1'b1, acc);
    compared++;
    if (o_we !== 1'b0 || o_status !== 4'b0001) begin
      mismatched++;
      $display("FAIL short_line: we=%b status=%b, required we=0 status=0001", o_we, o_status);
    end
    beat(32'h99, 1'b0, 1'b0, acc);
    compared++;
    if (acc !== 1'b1 || o_we !== 1'b0) begin
      mismatched++;
      $display("FAIL resync_drop: acc=%b we=%b, required acc=1 we=0", acc, o_we);
    end
    beat(32'h20, 1'b1, 1'b0, acc);
    compared++;
    if (o_we !== 1'b1 || o_waddr !== 14'd0 || o_wdata !== 32'h20) begin
      mismatched++;
      $display("FAIL resync_sof: we=%b addr=%0d data=%h, required we=1 addr=0 data=20", o_we, o_waddr, o_wdata);
    end
    for (int j = 1; j < 8; j++) beat(32'h20 + j, 1'b0, j == 3 || j == 7, acc);
    compared++;
    if (o_frame_done !== 1'b1 || o_waddr !== 14'd7) begin
      mismatched++;
      $display("FAIL resync_frame_end: done=%b addr=%0d, required done=1 addr=7", o_frame_done, o_waddr);
    end
    pulse_swap();
    pulse_clr();
    compared++;
    if (o_status !== 4'h0) begin
      mismatched++;
      $display("FAIL status_clear: got %b required 0000", o_status);
    end
  endtask

  task automatic test_long_line();
    for (int i = 0; i < 3; i++) beat(32'h40 + i, i == 0, 1'b0, acc);
    compared++;
    if (o_we !== 1'b1 || o_waddr !== 14'd2) begin
      mismatched++;
      $display("FAIL long_line_prefix: we=%b addr=%0d, required we=1 addr=2", o_we, o_waddr);
    end
    beat(32'h43, 1'b0, 1'b0, acc);
    compared++;
    if (o_we !== 1'b0 || o_status !== 4'b0010) begin
      mismatched++;
      $display("FAIL long_line: we=%b status=%b, required we=0 status=0010", o_we, o_status);
    end
    pulse_clr();
  endtask

  task automatic test_early_sof();
    for (int i = 0; i < 5; i++) beat(32'h50 + i, i == 0, i == 3, acc);
    beat(32'h55, 1'b1, 1'b0, acc);
    compared++;
    if (o_we !== 1'b1 || o_waddr !== 14'd0 || o_wdata !== 32'h55 || o_status !== 4'b0100) begin
      mismatched++;
      $display("FAIL early_sof: we=%b addr=%0d data=%h status=%b, required we=1 addr=0 data=55 status=0100",
               o_we, o_waddr, o_wdata, o_status);
    end
    for (int j = 1; j < 8; j++) begin
      beat(32'h60 + j, 1'b0, j == 3 || j == 7, acc);
      compared++;
      if (o_we !== 1'b1 || o_waddr !== 14'(j) || o_frame_done !== (j == 7)) begin
        mismatched++;
        $display("FAIL early_sof_beat%0d: we=%b addr=%0d done=%b, required we=1 addr=%0d done=%b",
                 j, o_we, o_waddr, o_frame_done, j, j == 7);
      end
    end
    pulse_swap();
    pulse_clr();
  endtask

  task automatic test_bad_config();
    ctrl_n_cols = 32'd0;
    beat(32'h70, 1'b1, 1'b0, acc);
    compared++;
    if (acc !== 1'b1 || o_we !== 1'b0 || o_status !== 4'b1000) begin
      mismatched++;
      $display("FAIL bad_config: acc=%b we=%b status=%b, required acc=1 we=0 status=1000", acc, o_we, o_status);
    end
    ctrl_n_cols = 32'd4;
    @(negedge clk);
    compared++;
    if (s_axis.tready !== 1'b1) begin
      mismatched++;
      $display("FAIL bad_config_idle_tready: got %b required 1", s_axis.tready);
    end
    pulse_clr();
  endtask

  task automatic test_disable();
    beat(32'h80, 1'b1, 1'b0, acc);
    beat(32'h81, 1'b0, 1'b0, acc);
    @(negedge clk);
    ctrl_en = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (s_axis.tready !== 1'b0) begin
      mismatched++;
      $display("FAIL disable_tready: got %b required 0", s_axis.tready);
    end
    s_axis.tvalid = 1'b1;
    s_axis.tlast  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      compared++;
      if (o_we !== 1'b0 || o_frame_done !== 1'b0 || s_axis.tready !== 1'b0) begin
        mismatched++;
        $display("FAIL disable_hold%0d: we=%b done=%b tready=%b, required 0 0 0", k, o_we, o_frame_done, s_axis.tready);
      end
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    @(negedge clk);
    ctrl_en = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (s_axis.tready !== 1'b1) begin
      mismatched++;
      $display("FAIL reenable_tready: got %b required 1", s_axis.tready);
    end
    beat(32'h82, 1'b0, 1'b0, acc);
    compared++;
    if (acc !== 1'b1 || o_we !== 1'b0 || o_status !== 4'h0) begin
      mismatched++;
      $display("FAIL reenable_idle_drop: acc=%b we=%b status=%b, required acc=1 we=0 status=0000", acc, o_we, o_status);
    end
  endtask

  task automatic test_reset_in_wait_swap();
    ctrl_n_rows = 32'd65;
    beat(32'h90, 1'b1, 1'b0, acc);
    ctrl_n_rows = 32'd2;
    for (int i = 0; i < 8; i++) beat(32'hA0 + i, i == 0, i == 3 || i == 7, acc);
    compared++;
    if (o_frame_done !== 1'b1 || o_status !== 4'b1000 || o_wdata !== 32'hA7) begin
      mismatched++;
      $display("FAIL pre_reset_frame: done=%b status=%b data=%h, required done=1 status=1000 data=a7",
               o_frame_done, o_status, o_wdata);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compared++;
    if (s_axis.tready !== 1'b0 || o_we !== 1'b0 || o_waddr !== '0 || o_wdata !== '0 ||
        o_wstrb !== '0 || o_frame_done !== 1'b0 || o_status !== '0) begin
      mismatched++;
      $display("FAIL async_reset: tready=%b we=%b addr=%0d data=%h strb=%h done=%b status=%b, required all zero",
               s_axis.tready, o_we, o_waddr, o_wdata, o_wstrb, o_frame_done, o_status);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
    test_reset();
    test_frame();
    test_short_line();
    test_long_line();
    test_early_sof();
    test_bad_config();
    test_disable();
    test_reset_in_wait_swap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
